// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, baud timing helpers and
// parity mode constants used by both the transmit and receive stages.
package uart_pkg;

  typedef enum logic [4:0] {
    RX_IDLE   = 5'b00001,
    RX_START  = 5'b00010,
    RX_DATA   = 5'b00100,
    RX_PARITY = 5'b01000,
    RX_STOP   = 5'b10000
  } rx_state_e;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;

  function automatic int unsigned baud_limit(input int unsigned clkf, input int unsigned baud);
    return (clkf / baud) - 1;
  endfunction

  function automatic int unsigned half_limit(input int unsigned clkf, input int unsigned baud);
    return baud_limit(clkf, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous serial line; resets to the idle
// (high) level so a reset never looks like a start edge.
module uart_sync (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling, optional even parity, valid/ready output.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each point.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD   = 921600,
  parameter int unsigned CLKF   = 100000000,
  parameter int unsigned DLEN   = 8,
  parameter int unsigned PARITY = PARITY_NONE
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_rxs,
  output logic            o_rvalid,
  input  logic            i_rready,
  output logic [DLEN-1:0] o_rdata,
  output logic            o_frame_err,
  output logic            o_parity_err,
  output logic            o_overrun
);

  localparam int unsigned BAUD_LIM = baud_limit(CLKF, BAUD);
  localparam int unsigned HALF_LIM = half_limit(CLKF, BAUD);
  localparam int unsigned BW       = $clog2(BAUD_LIM + 1);
  localparam int unsigned CW       = $clog2(DLEN + 1);

  localparam logic [BW-1:0] BL     = BW'(BAUD_LIM);
  localparam logic [BW-1:0] HL     = BW'(HALF_LIM);
  localparam logic [BW-1:0] ONE_B  = BW'(1);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [CW-1:0] LAST_C = CW'(DLEN - 1);

  rx_state_e       state_q, state_d;
  logic [BW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   bitc_q, bitc_d;
  logic [DLEN-1:0] shreg_q, shreg_d;
  logic            perr_q, perr_d;
  logic [DLEN-1:0] rdata_q, rdata_d;
  logic            ferr_q, ferr_d;
  logic            perr_out_q, perr_out_d;
  logic            rvalid_q, rvalid_d;
  logic            ovr_q, ovr_d;
  logic            rxs_prev_q;

  logic            rxs_s;
  logic            fall;
  logic [BW-1:0]   lim;
  logic            at_lim;
  logic            samp_fire;
  logic            samp_bit;
  logic            stop_fire;

  uart_sync u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (i_rxs),
    .q    (rxs_s)
  );

  assign fall   = rxs_prev_q & ~rxs_s;
  assign lim    = (state_q == RX_START) ? HL : BL;
  assign at_lim = (state_q != RX_IDLE) && (cnt_q == lim);

`ifdef UART_RX_MAJORITY_EN
  logic vm1_q, vm1_d;
  logic v0_q, v0_d;
  logic pend_q, pend_d;

  // Votes at N-1 and N are held; the decision uses the live line at N+1,
  // so every sample-driven event lands one clock after the count point.
  always_comb begin
    vm1_d  = vm1_q;
    v0_d   = v0_q;
    pend_d = at_lim;
    if ((state_q != RX_IDLE) && (cnt_q == lim - ONE_B)) vm1_d = rxs_s;
    if (at_lim) v0_d = rxs_s;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vm1_q  <= 1'b1;
      v0_q   <= 1'b1;
      pend_q <= 1'b0;
    end else begin
      vm1_q  <= vm1_d;
      v0_q   <= v0_d;
      pend_q <= pend_d;
    end
  end

  assign samp_fire = pend_q;
  assign samp_bit  = (vm1_q & v0_q) | (vm1_q & rxs_s) | (v0_q & rxs_s);
`else
  assign samp_fire = at_lim;
  assign samp_bit  = rxs_s;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bitc_d     = bitc_q;
    shreg_d    = shreg_q;
    perr_d     = perr_q;
    rdata_d    = rdata_q;
    ferr_d     = ferr_q;
    perr_out_d = perr_out_q;
    rvalid_d   = rvalid_q;
    ovr_d      = ovr_q;
    stop_fire  = 1'b0;

    if (rvalid_q && i_rready) begin
      rvalid_d = 1'b0;
      ovr_d    = 1'b0;
    end

    case (state_q)
      RX_IDLE: begin
        bitc_d = '0;
        perr_d = 1'b0;
        if (fall) state_d = RX_START;
      end
      RX_START: begin
        cnt_d = at_lim ? '0 : cnt_q + ONE_B;
        if (samp_fire) state_d = samp_bit ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        cnt_d = at_lim ? '0 : cnt_q + ONE_B;
        if (samp_fire) begin
          shreg_d = {samp_bit, shreg_q[DLEN-1:1]};
          bitc_d  = bitc_q + ONE_C;
          if (bitc_q == LAST_C) begin
            bitc_d  = '0;
            state_d = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
          end
        end
      end
      RX_PARITY: begin
        cnt_d = at_lim ? '0 : cnt_q + ONE_B;
        if (samp_fire) begin
          perr_d  = samp_bit ^ (^shreg_q);
          state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        cnt_d = at_lim ? '0 : cnt_q + ONE_B;
        if (samp_fire) begin
          stop_fire = 1'b1;
          state_d   = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase

    if (state_d == RX_IDLE) cnt_d = '0;

    // A same-cycle handshake frees the output register for the new word.
    if (stop_fire) begin
      if (!rvalid_q || i_rready) begin
        rdata_d    = shreg_q;
        ferr_d     = ~samp_bit;
        perr_out_d = perr_q;
        rvalid_d   = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      bitc_q     <= '0;
      shreg_q    <= '0;
      perr_q     <= 1'b0;
      rdata_q    <= '0;
      ferr_q     <= 1'b0;
      perr_out_q <= 1'b0;
      rvalid_q   <= 1'b0;
      ovr_q      <= 1'b0;
      rxs_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitc_q     <= bitc_d;
      shreg_q    <= shreg_d;
      perr_q     <= perr_d;
      rdata_q    <= rdata_d;
      ferr_q     <= ferr_d;
      perr_out_q <= perr_out_d;
      rvalid_q   <= rvalid_d;
      ovr_q      <= ovr_d;
      rxs_prev_q <= rxs_s;
    end
  end

  assign o_rvalid     = rvalid_q;
  assign o_rdata      = rdata_q;
  assign o_frame_err  = ferr_q;
  assign o_parity_err = perr_out_q;
  assign o_overrun    = ovr_q;

endmodule
